// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared types and constants for the "10101" sequence detector
package seqdet_pkg;

    // State code equals the length-ordered matched prefix; it appears on uo_out[4:2].
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1010 = 3'd4
    } state_t;

    localparam logic [4:0] PATTERN = 5'b10101;
    localparam int         CNT_W   = 3;

endpackage

// File: rtl/seqdet_fsm.sv
// rtl/seqdet_fsm.sv - overlapping "10101" prefix FSM with state register and hit decode
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_en     advance enable; state holds when low
//   i_bit    serial data bit sampled this cycle
//   o_state  current (registered) state
//   o_hit    combinational: the bit being sampled now completes the pattern
module seqdet_fsm
    import seqdet_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_en,
    input  logic   i_bit,
    output state_t o_state,
    output logic   o_hit
);

    state_t r_state;
    state_t w_next;
    logic   w_hit;

    always_comb begin
        w_next = r_state;
        w_hit  = 1'b0;
        case (r_state)
            S0:    w_next = i_bit ? S1   : S0;
            S1:    w_next = i_bit ? S1   : S10;
            S10:   w_next = i_bit ? S101 : S0;
            S101:  w_next = i_bit ? S1   : S1010;
            S1010: begin
                // A hit falls back to S101 so the trailing "101" seeds the next match.
                w_next = i_bit ? S101 : S0;
                w_hit  = (i_bit == PATTERN[0]);
            end
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S0;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;
    assign o_hit   = w_hit;

endmodule

// File: rtl/tt_um_marxkar_seq_detect.sv
// rtl/tt_um_marxkar_seq_detect.sv - TinyTapeout tile: serial "10101" detector with sticky flag, pulse and hit counter
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable; low freezes all state and ignores clear
//   ui_in    [0] serial bit, [1] clear sticky flag and counter, [7:2] unused
//   uo_out   [0] sticky detect, [1] hit pulse, [4:2] FSM state, [7:5] saturating hit count
//   uio_in   unused
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins inputs)
module tt_um_marxkar_seq_detect
    import seqdet_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t           w_state;
    logic             w_hit;
    logic             w_clear;
    logic             r_sticky;
    logic             r_pulse;
    logic [CNT_W-1:0] r_count;

    assign w_clear = ui_in[1];

    seqdet_fsm u_fsm (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (ena),
        .i_bit   (ui_in[0]),
        .o_state (w_state),
        .o_hit   (w_hit)
    );

    // Clear has priority over a coincident hit for the sticky flag and counter,
    // but the pulse still reports the hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_pulse  <= 1'b0;
            r_count  <= '0;
        end else if (ena) begin
            r_pulse <= w_hit;
            if (w_clear) begin
                r_sticky <= 1'b0;
                r_count  <= '0;
            end else if (w_hit) begin
                r_sticky <= 1'b1;
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign uo_out  = {r_count, w_state, r_pulse, r_sticky};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic w_unused;
    assign w_unused = &{1'b0, ui_in[7:2], uio_in};

endmodule

// File: tb/tb_tt_um_marxkar_seq_detect.sv
// tb/tb_tt_um_marxkar_seq_detect.sv - directed self-checking bench for the "10101" detector tile
module tb_tt_um_marxkar_seq_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec  = 0;
    int n_fail = 0;

    tt_um_marxkar_seq_detect dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // uo_out = {count[2:0], state[2:0], pulse, sticky}
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a bit, let one rising edge sample it, then settle 2ns past the edge.
    task automatic step(input logic b);
        ui_in[0] = b;
        @(posedge clk);
        #2;
    endtask

    // Called 2ns after a rising edge; reset spans the following falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // 1. reset
        #20;
        rst_n = 1'b1;
        #1;
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);

        // 2. 10101 then two extra ones
        step(1'b1); chk("t2_b1_S1", uo_out, 8'h04);
        step(1'b0); chk("t2_b2_S10", uo_out, 8'h08);
        step(1'b1); chk("t2_b3_S101", uo_out, 8'h0C);
        step(1'b0); chk("t2_b4_S1010", uo_out, 8'h10);
        step(1'b1); chk("t2_hit", uo_out, 8'h2F);
        step(1'b1); chk("t2_pulse_drop", uo_out, 8'h25);
        step(1'b1); chk("t2_sticky_hold", uo_out, 8'h25);

        // 3a. overlapped 1010101
        do_reset();
        #1; chk("t3_reset", uo_out, 8'h00);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        step(1'b1); chk("t3_hit1", uo_out, 8'h2F);
        step(1'b0); chk("t3_between", uo_out, 8'h31);
        step(1'b1); chk("t3_hit2", uo_out, 8'h4F);

        // 3b. 11011011 has no hit
        ui_in[0] = 1'b0;
        @(posedge clk); #2;
        do_reset();
        step(1'b1); step(1'b1); step(1'b0);
        step(1'b1); chk("t3_nohit_S101", uo_out, 8'h0C);
        step(1'b1); step(1'b0); step(1'b1);
        step(1'b1); chk("t3_nohit_end", uo_out, 8'h04);

        // 4a. hit, then clear; FSM keeps advancing
        step(1'b0); step(1'b1); step(1'b0);
        step(1'b1); chk("t4_hit", uo_out, 8'h2F);
        ui_in[1] = 1'b1;
        step(1'b0); chk("t4_clear", uo_out, 8'h10);
        // clear coincident with a hit: pulse yes, sticky/count stay 0
        step(1'b1); chk("t4_clear_vs_hit", uo_out, 8'h0E);
        ui_in[1] = 1'b0;

        // 4b. nine overlapped hits from S101 -> count saturates at 7
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            step(1'b1);
        end
        chk("t4_count7", uo_out, 8'hEF);
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            step(1'b1);
        end
        chk("t4_sat_hit9", uo_out, 8'hEF);
        step(1'b0); chk("t4_sat_hold", uo_out, 8'hF1);

        // 5. ena=0 freezes everything, clear included
        do_reset();
        ena = 1'b0;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        chk("t5_frozen_mid", uo_out, 8'h00);
        ui_in[1] = 1'b1;
        step(1'b1); chk("t5_frozen_end", uo_out, 8'h00);
        ui_in[1] = 1'b0;
        ena = 1'b1;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        step(1'b1); chk("t5_reenable_hit", uo_out, 8'h2F);

        // freeze with sticky/count nonzero, clear asserted: held
        ena = 1'b0;
        ui_in[1] = 1'b1;
        step(1'b0); chk("t5_hold_nonzero", uo_out, 8'h2F);
        ui_in[1] = 1'b0;
        ena = 1'b1;

        // 6. asynchronous reset mid-sequence
        do_reset();
        step(1'b1); step(1'b0); step(1'b1);
        step(1'b0); chk("t6_S1010", uo_out, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", uo_out, 8'h00);
        #2;
        rst_n = 1'b1;
        step(1'b1); chk("t6_single_one", uo_out, 8'h04);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        step(1'b1); chk("t6_full_hit", uo_out, 8'h2F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
